// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB CSR arbiter.
// Timeout logic is enabled by defining APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Wide enough for any practical wait-state limit.
  localparam int TMO_CNT_W = 16;

  function automatic int req_idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches from last_grant+1 upward,
// wrapping modulo NUM_REQ, skipping masked requesters.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  localparam int REQ_IDX_W = req_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_mask,
  input  logic [REQ_IDX_W-1:0] i_last_grant,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [REQ_IDX_W-1:0] o_idx,
  output logic                 o_valid
);

  logic [NUM_REQ-1:0]   w_elig;
  logic [REQ_IDX_W-1:0] w_cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign w_elig[gi] = i_req[gi] & ~i_mask[gi];
  end

  // Walk the offsets from farthest to nearest so the nearest eligible
  // requester after last_grant is the final assignment.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = REQ_IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (w_elig[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_csr_arbiter.sv
// Round-robin arbiter + APB master sequencer sharing one CSR slave port.
// Optional wait-state timeout abort: define APB_ARB_TIMEOUT_EN.
module apb_csr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          hrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata
);

  localparam int REQ_IDX_W = req_idx_w(NUM_REQ);

  state_t                 r_state, w_state_next;
  logic [REQ_IDX_W-1:0]   r_last_grant;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [NUM_REQ-1:0]     r_done;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [ADDR_WIDTH-1:0]  r_paddr;
  logic                   r_pwrite;
  logic [DATA_WIDTH-1:0]  r_pwdata;

  logic                   w_grant_en;
  logic                   w_complete;
  logic                   w_psel;
  logic                   w_penable;
  logic [NUM_REQ-1:0]     w_arb_gnt;
  logic [REQ_IDX_W-1:0]   w_arb_idx;
  logic                   w_arb_valid;

  logic [ADDR_WIDTH-1:0]  w_req_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  w_req_wdata [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_req_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // The requester in its done cycle is masked so it has time to drop req.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req        (req),
    .i_mask       (r_done),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_arb_gnt),
    .o_idx        (w_arb_idx),
    .o_valid      (w_arb_valid)
  );

`ifdef APB_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] r_tmo_cnt;
  logic                 r_err;
  logic                 w_abort;

  always_ff @(posedge pclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ACCESS && !pready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge pclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_complete   = 1'b0;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    w_abort      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_grant_en   = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        w_psel       = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (pready) begin
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // pready wins over the limit; otherwise the last wait cycle aborts.
        else if (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_last_grant <= REQ_IDX_W'(NUM_REQ - 1);
      r_gnt        <= '0;
      r_done       <= '0;
      r_rdata      <= '0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_done <= '0;
      if (w_grant_en) begin
        r_gnt        <= w_arb_gnt;
        r_last_grant <= w_arb_idx;
        r_paddr      <= w_req_addr[w_arb_idx];
        r_pwrite     <= req_write[w_arb_idx];
        r_pwdata     <= w_req_wdata[w_arb_idx];
      end
      if (w_complete) begin
        r_done  <= r_gnt;
        r_gnt   <= '0;
        r_rdata <= r_pwrite ? '0 : prdata;
`ifdef APB_ARB_TIMEOUT_EN
        r_err   <= 1'b0;
`endif
      end
`ifdef APB_ARB_TIMEOUT_EN
      if (w_abort) begin
        r_done  <= r_gnt;
        r_gnt   <= '0;
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
`endif
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign psel    = w_psel;
  assign penable = w_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
`ifdef APB_ARB_TIMEOUT_EN
  assign err     = r_err;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_csr_arbiter.sv
// Directed self-checking bench for apb_csr_arbiter (NUM_REQ=2, 32-bit).
// Covers the APB_ARB_TIMEOUT_EN build when that macro is defined.
module tb_apb_csr_arbiter;

  logic        pclk = 1'b0;
  logic        hrst_n;
  logic [1:0]  req, req_write, gnt, done;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rdata, paddr, pwdata, prdata;
  logic        err, psel, penable, pwrite, pready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_csr_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .hrst_n(hrst_n), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    hrst_n = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    #3;
    n_checks++; if (gnt !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_done: got gnt=%b done=%b need 00 00", gnt, done); end
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_apb_ctl: got psel=%b penable=%b pwrite=%b need 0", psel, penable, pwrite); end
    n_checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || rdata !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h err=%b need 0", paddr, pwdata, rdata, err); end
    tick(); tick();
    hrst_n = 1'b1;
    $display("txn reset: outputs checked at reset");
  endtask

  task automatic test_single_write();
    req = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h04; req_wdata[31:0] = 32'h0000_00C2; pready = 1'b1;
    tick();
    n_checks++; if (gnt !== 2'b01 || psel !== 1'b1 || penable !== 1'b0) begin n_fail++; $display("FAIL wr_setup: got gnt=%b psel=%b penable=%b need 01 1 0", gnt, psel, penable); end
    n_checks++; if (paddr !== 32'h04 || pwrite !== 1'b1 || pwdata !== 32'hC2) begin n_fail++; $display("FAIL wr_bus: got paddr=%h pwrite=%b pwdata=%h need 04 1 c2", paddr, pwrite, pwdata); end
    tick();
    n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || done !== 2'b00) begin n_fail++; $display("FAIL wr_access: got psel=%b penable=%b done=%b need 1 1 00", psel, penable, done); end
    tick();
    n_checks++; if (done !== 2'b01 || err !== 1'b0 || gnt !== 2'b00 || psel !== 1'b0) begin n_fail++; $display("FAIL wr_done: got done=%b err=%b gnt=%b psel=%b need 01 0 00 0", done, err, gnt, psel); end
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b00 || psel !== 1'b0) begin n_fail++; $display("FAIL wr_after: got done=%b psel=%b need 00 0", done, psel); end
    $display("txn write: req0 addr=04 data=c2");
  endtask

  task automatic test_single_read();
    req = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h0; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (gnt !== 2'b10 || pwrite !== 1'b0 || paddr !== 32'h0) begin n_fail++; $display("FAIL rd_setup: got gnt=%b pwrite=%b paddr=%h need 10 0 0", gnt, pwrite, paddr); end
    tick(); tick();
    n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || done !== 2'b00) begin n_fail++; $display("FAIL rd_wait: got psel=%b penable=%b done=%b need 1 1 00", psel, penable, done); end
    pready = 1'b1;
    tick();
    n_checks++; if (done !== 2'b10 || rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin n_fail++; $display("FAIL rd_done: got done=%b rdata=%h err=%b need 10 deadbeef 0", done, rdata, err); end
    req = 2'b00; prdata = 32'h1111_2222;
    tick();
    n_checks++; if (done !== 2'b00 || rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_hold: got done=%b rdata=%h need 00 deadbeef", done, rdata); end
    $display("txn read: req1 addr=00 rdata=%h", rdata);
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    req = 2'b11; req_write = 2'b11; pready = 1'b1;
    req_addr  = {32'h0000_0010, 32'h0000_0008};
    req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int t = 0; t < 8; t++) begin
      exp_gnt  = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (t % 2 == 0) ? 32'h08 : 32'h10;
      tick();
      n_checks++; if (gnt !== exp_gnt || paddr !== exp_addr) begin n_fail++; $display("FAIL cont_gnt%0d: got gnt=%b paddr=%h need %b %h", t, gnt, paddr, exp_gnt, exp_addr); end
      tick(); tick();
      n_checks++; if (done !== exp_gnt || rdata !== 32'h0) begin n_fail++; $display("FAIL cont_done%0d: got done=%b rdata=%h need %b 0", t, done, rdata, exp_gnt); end
      if (t == 7) req = 2'b00;
      $display("txn contention %0d: gnt=%b", t, exp_gnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    req = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h0C; pready = 1'b1;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt: got gnt=%b need 01", gnt); end
    tick(); tick();
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL b2b_done: got done=%b need 01", done); end
    tick();
    n_checks++; if (gnt !== 2'b00 || psel !== 1'b0) begin n_fail++; $display("FAIL b2b_mask: got gnt=%b psel=%b need 00 0", gnt, psel); end
    req = 2'b00;
    tick();
    n_checks++; if (gnt !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got gnt=%b done=%b need 00 00", gnt, done); end
    $display("txn back_to_back: req0 single grant");
  endtask

  task automatic test_reset_mid_access();
    req = 2'b11; req_write = 2'b11; pready = 1'b0;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rst_pre_gnt: got gnt=%b need 10", gnt); end
    tick(); tick();
    hrst_n = 1'b0;
    #1;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL rst_async: got psel=%b penable=%b gnt=%b done=%b need 0 0 00 00", psel, penable, gnt, done); end
    tick();
    hrst_n = 1'b1; pready = 1'b1;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_prio: got gnt=%b need 01", gnt); end
    tick(); tick();
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL rst_done0: got done=%b need 01", done); end
    req = 2'b10;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rst_gnt1: got gnt=%b need 10", gnt); end
    tick(); tick();
    n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL rst_done1: got done=%b need 10", done); end
    req = 2'b00;
    tick();
    $display("txn reset_mid_access: transfer dropped, req0 then req1 served");
  endtask

  task automatic test_timeout();
    req = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h0C; pready = 1'b0; prdata = 32'hAAAA_5555;
    tick(); tick();
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (done !== 2'b00 || psel !== 1'b1) begin n_fail++; $display("FAIL tmo_pre: got done=%b psel=%b need 00 1", done, psel); end
    tick();
    n_checks++; if (done !== 2'b01 || err !== 1'b1 || rdata !== 32'h0 || psel !== 1'b0) begin n_fail++; $display("FAIL tmo_abort: got done=%b err=%b rdata=%h psel=%b need 01 1 0 0", done, err, rdata, psel); end
    req = 2'b00;
    tick();
    req = 2'b01; pready = 1'b1; prdata = 32'h1234_5678;
    tick(); tick(); tick();
    n_checks++; if (done !== 2'b01 || err !== 1'b0 || rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL tmo_next: got done=%b err=%b rdata=%h need 01 0 12345678", done, err, rdata); end
`else
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (done !== 2'b00 || psel !== 1'b1 || penable !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL notmo_wait: got done=%b psel=%b penable=%b err=%b need 00 1 1 0", done, psel, penable, err); end
    pready = 1'b1;
    tick();
    n_checks++; if (done !== 2'b01 || err !== 1'b0 || rdata !== 32'hAAAA_5555) begin n_fail++; $display("FAIL notmo_done: got done=%b err=%b rdata=%h need 01 0 aaaa5555", done, err, rdata); end
`endif
    req = 2'b00;
    tick();
    $display("txn timeout scenario: rdata=%h err=%b", rdata, err);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
